// File: rtl/rx_pkg.sv
// Shared receive-path definitions: sync header codes, block/slice geometry and the
// block-lock state encoding used by the aligner and its helpers.
package rx_pkg;

  localparam logic [1:0] c_DATA_HEADER = 2'b01;
  localparam logic [1:0] c_CMD_HEADER  = 2'b10;
  localparam int         c_BLOCK_W     = 66;
  localparam int         c_SLICE_W     = 67;
  localparam int         c_HIST_W      = 2 * c_SLICE_W;
  localparam int         c_MAX_OFFSET  = 65;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } lock_state_t;

  function automatic logic header_ok(input logic [1:0] hdr);
    return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
  endfunction

endpackage

// File: rtl/block_aligner_if.sv
// Gearbox-to-aligner input bundle plus the aligned-block output bundle.
// The master side is the producer/consumer around the aligner; the slave side is the aligner.
interface block_aligner_if;

  logic [193:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic         buffer_dv;
  logic [6:0]   block_offset;
  logic [1:0]   header_o;
  logic [63:0]  data_o;
  logic         data_valid_o;
  logic         locked_o;
  logic [6:0]   lock_offset_o;
  logic         hdr_err_o;

  modport master (
    output gbox_buffer, gbox_cnt, buffer_dv, block_offset,
    input  header_o, data_o, data_valid_o, locked_o, lock_offset_o, hdr_err_o
  );

  modport slave (
    input  gbox_buffer, gbox_cnt, buffer_dv, block_offset,
    output header_o, data_o, data_valid_o, locked_o, lock_offset_o, hdr_err_o
  );

endinterface

// File: rtl/block_extract.sv
// Combinational barrel select of one 66b block (header + payload) out of the
// 134-bit slice history; the block's top bit sits at history bit 68+offset.
module block_extract
  import rx_pkg::*;
(
  input  logic [c_HIST_W-1:0] hist_i,
  input  logic [6:0]          offset_i,
  output logic [1:0]          header_o,
  output logic [63:0]         payload_o
);

  logic [7:0]           shift_amt;
  logic [c_BLOCK_W-1:0] blk;

  always_comb begin
    shift_amt = {1'b0, offset_i} + 8'd3;
    blk       = c_BLOCK_W'(hist_i >> shift_amt);
    header_o  = blk[c_BLOCK_W-1 -: 2];
    payload_o = blk[63:0];
  end

endmodule

// File: rtl/block_aligner.sv
// Block lock for the 64b/66b receive path: qualifies the synchroniser's header offset
// (hunt/check/lock), then emits aligned blocks and drops lock on a high header error rate.
module block_aligner
  import rx_pkg::*;
#(
  parameter int LOCK_CNT = 32,
  parameter int WIN_LEN  = 64,
  parameter int BAD_MAX  = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  block_aligner_if.slave   bus
);

  localparam logic [6:0] c_LOCK_CNT = 7'(LOCK_CNT);
  localparam logic [6:0] c_WIN_LEN  = 7'(WIN_LEN);
  localparam logic [6:0] c_BAD_MAX  = 7'(BAD_MAX);

  logic [c_SLICE_W-1:0] cur_slice_q, cur_slice_d;
  logic [c_SLICE_W-1:0] prev_slice_q, prev_slice_d;
  logic                 eval_q, eval_d;
  lock_state_t          state_q, state_d;
  logic [6:0]           offset_q, offset_d;
  logic [6:0]           good_cnt_q, good_cnt_d;
  logic [6:0]           blk_cnt_q, blk_cnt_d;
  logic [6:0]           bad_cnt_q, bad_cnt_d;
  logic [1:0]           header_q, header_d;
  logic [63:0]          data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 locked_q, locked_d;
  logic                 hdr_err_q, hdr_err_d;

  logic [7:0]           slice_lo;
  logic [c_SLICE_W-1:0] new_slice;
  logic [1:0]           ext_header;
  logic [63:0]          ext_payload;
  logic                 hdr_ok;
  logic [6:0]           blk_inc;
  logic [6:0]           bad_inc;

  // Window position gbox_cnt selects buffer bits [193-cnt : 127-cnt].
  always_comb begin
    slice_lo     = 8'd127 - {2'b00, bus.gbox_cnt};
    new_slice    = c_SLICE_W'(bus.gbox_buffer >> slice_lo);
    cur_slice_d  = cur_slice_q;
    prev_slice_d = prev_slice_q;
    eval_d       = bus.buffer_dv;
    if (bus.buffer_dv) begin
      cur_slice_d  = new_slice;
      prev_slice_d = cur_slice_q;
    end
  end

  block_extract u_extract (
    .hist_i    ({prev_slice_q, cur_slice_q}),
    .offset_i  (offset_q),
    .header_o  (ext_header),
    .payload_o (ext_payload)
  );

  always_comb begin
    hdr_ok       = header_ok(ext_header);
    blk_inc      = blk_cnt_q + 7'd1;
    bad_inc      = bad_cnt_q + {6'd0, ~hdr_ok};
    state_d      = state_q;
    offset_d     = offset_q;
    good_cnt_d   = good_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    header_d     = header_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    hdr_err_d    = 1'b0;
    locked_d     = locked_q;

    if (eval_q) begin
      case (state_q)
        HUNT: begin
          if (bus.block_offset <= 7'(c_MAX_OFFSET)) begin
            offset_d   = bus.block_offset;
            good_cnt_d = 7'd0;
            state_d    = CHECK;
          end
        end
        CHECK: begin
          if (!hdr_ok) begin
            good_cnt_d = 7'd0;
            state_d    = HUNT;
          end else if (good_cnt_q + 7'd1 == c_LOCK_CNT) begin
            good_cnt_d = 7'd0;
            blk_cnt_d  = 7'd0;
            bad_cnt_d  = 7'd0;
            locked_d   = 1'b1;
            state_d    = LOCKED;
          end else begin
            good_cnt_d = good_cnt_q + 7'd1;
          end
        end
        LOCKED: begin
          // Bad blocks are still emitted so the descrambler side can see them.
          data_valid_d = 1'b1;
          header_d     = ext_header;
          data_d       = ext_payload;
          hdr_err_d    = ~hdr_ok;
          if (bad_inc == c_BAD_MAX) begin
            blk_cnt_d = 7'd0;
            bad_cnt_d = 7'd0;
            locked_d  = 1'b0;
            state_d   = HUNT;
          end else if (blk_inc == c_WIN_LEN) begin
            blk_cnt_d = 7'd0;
            bad_cnt_d = 7'd0;
          end else begin
            blk_cnt_d = blk_inc;
            bad_cnt_d = bad_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_slice_q  <= '0;
      prev_slice_q <= '0;
      eval_q       <= 1'b0;
      state_q      <= HUNT;
      offset_q     <= 7'd0;
      good_cnt_q   <= 7'd0;
      blk_cnt_q    <= 7'd0;
      bad_cnt_q    <= 7'd0;
      header_q     <= 2'b00;
      data_q       <= 64'd0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      cur_slice_q  <= cur_slice_d;
      prev_slice_q <= prev_slice_d;
      eval_q       <= eval_d;
      state_q      <= state_d;
      offset_q     <= offset_d;
      good_cnt_q   <= good_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      header_q     <= header_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  assign bus.header_o      = header_q;
  assign bus.data_o        = data_q;
  assign bus.data_valid_o  = data_valid_q;
  assign bus.locked_o      = locked_q;
  assign bus.lock_offset_o = offset_q;
  assign bus.hdr_err_o     = hdr_err_q;

endmodule

// File: tb/tb_block_aligner.sv
// Directed bench for block_aligner: builds a 66b block stream at header offset 17
// and checks lock timing, emitted blocks, error windows, illegal offsets and reset.
module tb_block_aligner;

  logic clk;
  logic rst;
  int   total_cnt;
  int   bad_cnt;
  int   err_seen;
  int   valid_in_reset;
  logic [65:0] emitted[$];
  bit   bad_flag [0:511];

  block_aligner_if bus_if ();

  block_aligner dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor samples 1 time unit after each rising edge, away from the negedge driver.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (bus_if.data_valid_o || bus_if.hdr_err_o) valid_in_reset++;
    end else begin
      if (bus_if.data_valid_o) emitted.push_back({bus_if.header_o, bus_if.data_o});
      if (bus_if.hdr_err_o) err_seen++;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] blk(input int k);
    logic [15:0] kk;
    logic [1:0]  h;
    logic [63:0] p;
    kk = 16'(k);
    h  = bad_flag[k] ? 2'b11 : (kk[0] ? 2'b01 : 2'b10);
    p  = {kk, 16'hBEEF, ~kk, 16'h0000} | 64'h0000_0000_0030_0000;
    return {h, p};
  endfunction

  // Slice j carries block j's low 47 bits on top and block j+1's top 19 bits below,
  // so with offset 17 the history {slice j-1, slice j} holds block j at bits 85..20.
  task automatic applyStimulus(input int j);
    logic [65:0]  b0;
    logic [65:0]  b1;
    logic [66:0]  sl;
    logic [193:0] buf_v;
    int           c;
    b0    = blk(j);
    b1    = blk(j + 1);
    sl    = {b0[46:0], 1'b0, b1[65:47]};
    buf_v = 194'({$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom()});
    c     = j % 64;
    buf_v[193 - c -: 67] = sl;
    @(negedge clk);
    bus_if.gbox_buffer = buf_v;
    bus_if.gbox_cnt    = 6'(c);
    bus_if.buffer_dv   = 1'b1;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    bus_if.buffer_dv = 1'b0;
  endtask

  task automatic sendRange(input int first, input int last);
    for (int j = first; j <= last; j++) applyStimulus(j);
  endtask

  task automatic clearMonitor();
    emitted.delete();
    err_seen = 0;
  endtask

  function automatic logic [65:0] emittedAt(input int i);
    if (i < emitted.size()) return emitted[i];
    return 66'd0;
  endfunction

  initial begin
    total_cnt      = 0;
    bad_cnt        = 0;
    err_seen       = 0;
    valid_in_reset = 0;
    rst            = 1'b1;
    bus_if.gbox_buffer  = '0;
    bus_if.gbox_cnt     = 6'd0;
    bus_if.buffer_dv    = 1'b0;
    bus_if.block_offset = 7'd17;
    for (int m = 0; m < 15; m++) bad_flag[41 + 3 * m] = 1'b1;
    for (int m = 0; m < 16; m++) bad_flag[100 + 2 * m] = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.buffer_dv   = (i % 2 == 0);
      bus_if.gbox_buffer = 194'({$urandom(), $urandom(), $urandom(), $urandom(),
                                 $urandom(), $urandom(), $urandom()});
    end
    @(negedge clk);
    checkOutput("rst_locked", bus_if.locked_o, 1'b0);
    checkOutput("rst_valid", bus_if.data_valid_o, 1'b0);
    checkOutput("rst_hdr_err", bus_if.hdr_err_o, 1'b0);
    checkOutput("rst_offset", bus_if.lock_offset_o, 7'd0);
    checkOutput("rst_header", bus_if.header_o, 2'b00);
    checkOutput("rst_data", bus_if.data_o, 64'd0);
    checkOutput("rst_strobes", valid_in_reset, 0);

    rst              = 1'b0;
    bus_if.buffer_dv = 1'b0;
    clearMonitor();
    sendRange(0, 32);
    idleCycle();
    checkOutput("lock_early", bus_if.locked_o, 1'b0);
    idleCycle();
    checkOutput("lock_rise", bus_if.locked_o, 1'b1);
    checkOutput("lock_offset", bus_if.lock_offset_o, 7'd17);
    checkOutput("no_emit_before_lock", emitted.size(), 0);

    sendRange(33, 40);
    idleCycle();
    idleCycle();
    checkOutput("emit_count", emitted.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("emit_blk%0d", 33 + i), emittedAt(i), blk(33 + i));

    clearMonitor();
    sendRange(41, 96);
    idleCycle();
    idleCycle();
    checkOutput("win1_errs", err_seen, 15);
    checkOutput("win1_locked", bus_if.locked_o, 1'b1);
    checkOutput("win1_emits", emitted.size(), 56);

    clearMonitor();
    sendRange(97, 129);
    idleCycle();
    idleCycle();
    checkOutput("win2_errs15", err_seen, 15);
    checkOutput("win2_still_locked", bus_if.locked_o, 1'b1);
    clearMonitor();
    applyStimulus(130);
    bus_if.block_offset = 7'd100;
    idleCycle();
    idleCycle();
    checkOutput("loss_locked", bus_if.locked_o, 1'b0);
    checkOutput("loss_err", err_seen, 1);
    checkOutput("loss_emit_count", emitted.size(), 1);
    checkOutput("loss_emit_blk", emittedAt(0), blk(130));

    clearMonitor();
    sendRange(131, 135);
    idleCycle();
    idleCycle();
    checkOutput("illegal_locked", bus_if.locked_o, 1'b0);
    checkOutput("illegal_emits", emitted.size(), 0);
    checkOutput("illegal_offset_held", bus_if.lock_offset_o, 7'd17);

    bus_if.block_offset = 7'd40;
    sendRange(136, 137);
    idleCycle();
    idleCycle();
    checkOutput("false_offset", bus_if.lock_offset_o, 7'd40);
    checkOutput("false_locked", bus_if.locked_o, 1'b0);
    bus_if.block_offset = 7'd17;
    sendRange(138, 170);
    idleCycle();
    checkOutput("relock_early", bus_if.locked_o, 1'b0);
    idleCycle();
    checkOutput("relock_rise", bus_if.locked_o, 1'b1);
    checkOutput("relock_offset", bus_if.lock_offset_o, 7'd17);

    bus_if.block_offset = 7'd5;
    clearMonitor();
    sendRange(171, 175);
    idleCycle();
    idleCycle();
    checkOutput("midlock_offset", bus_if.lock_offset_o, 7'd17);
    checkOutput("midlock_emits", emitted.size(), 5);
    checkOutput("midlock_blk", emittedAt(4), blk(175));

    clearMonitor();
    valid_in_reset = 0;
    sendRange(176, 178);
    checkOutput("pre_reset_locked", bus_if.locked_o, 1'b1);
    rst = 1'b1;
    idleCycle();
    checkOutput("mid_reset_locked", bus_if.locked_o, 1'b0);
    checkOutput("mid_reset_valid", bus_if.data_valid_o, 1'b0);
    idleCycle();
    rst = 1'b0;
    checkOutput("mid_reset_emits", emitted.size(), 1);
    checkOutput("mid_reset_blk", emittedAt(0), blk(176));
    checkOutput("mid_reset_strobes", valid_in_reset, 0);
    bus_if.block_offset = 7'd17;
    sendRange(182, 214);
    idleCycle();
    checkOutput("post_reset_early", bus_if.locked_o, 1'b0);
    idleCycle();
    checkOutput("post_reset_lock", bus_if.locked_o, 1'b1);
    clearMonitor();
    sendRange(215, 217);
    idleCycle();
    idleCycle();
    checkOutput("post_reset_emits", emitted.size(), 3);
    checkOutput("post_reset_blk", emittedAt(0), blk(215));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
